// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
package grf_arb_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    localparam int unsigned DEPTH_DEF      = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // One buffered long-latency result; valid drops when the entry is killed or popped.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } pend_entry_t;

    localparam int unsigned ENTRY_W = $bits(pend_entry_t);

endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Bus bundle between the pipeline/LU source and the GRF write arbiter.
interface grf_wr_arbiter_if;
    import grf_arb_pkg::*;

    // Writeback stage request
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // Long-latency result handshake
    logic              lu_valid;
    logic [ADDR_W-1:0] lu_addr;
    logic [DATA_W-1:0] lu_data;
    logic              lu_ready;
    // Decode-stage forwarding lookup
    logic [ADDR_W-1:0] qry_rs;
    logic [ADDR_W-1:0] qry_rt;
    logic              fwd_rs_hit;
    logic              fwd_rt_hit;
    logic [DATA_W-1:0] fwd_rs_data;
    logic [DATA_W-1:0] fwd_rt_data;
    // GRF write port and pipeline stall
    logic              RegWr;
    logic [ADDR_W-1:0] RWAddr;
    logic [DATA_W-1:0] RWData;
    logic              stall_GRF;

    modport master (
        output wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, qry_rs, qry_rt,
        input  lu_ready, fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
        input  RegWr, RWAddr, RWData, stall_GRF
    );

    modport slave (
        input  wb_we, wb_addr, wb_data, lu_valid, lu_addr, lu_data, qry_rs, qry_rt,
        output lu_ready, fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data,
        output RegWr, RWAddr, RWData, stall_GRF
    );

endinterface

// File: rtl/grf_pend_fifo.sv
// Pending-result FIFO: storage, pointers, kill-by-address and newest-match forwarding.
module grf_pend_fifo
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_addr,
    input  logic [ADDR_W-1:0] qry_rs,
    input  logic [ADDR_W-1:0] qry_rt,
    output logic              empty,
    output logic              full,
    output pend_entry_t       head,
    output logic              rs_hit,
    output logic [DATA_W-1:0] rs_data,
    output logic              rt_hit,
    output logic [DATA_W-1:0] rt_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    pend_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] idx;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign head  = mem_q[head_q];

    // Storage update: kill matching entries, retire the head, append at the tail.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && mem_q[i].valid && (mem_q[i].addr == kill_addr)) begin
                    mem_q[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem_q[head_q].valid <= 1'b0;
                head_q              <= head_q + 1'b1;
            end
            // Tail slot is never occupied here, so the push cannot collide with kill/pop.
            if (push) begin
                mem_q[tail_q] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                tail_q        <= tail_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Walk oldest to newest so the last match (the newest entry) wins.
    always_comb begin
        rs_hit  = 1'b0;
        rs_data = '0;
        rt_hit  = 1'b0;
        rt_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (mem_q[idx].valid && (qry_rs != REG_ZERO) && (mem_q[idx].addr == qry_rs)) begin
                rs_hit  = 1'b1;
                rs_data = mem_q[idx].data;
            end
            if (mem_q[idx].valid && (qry_rt != REG_ZERO) && (mem_q[idx].addr == qry_rt)) begin
                rt_hit  = 1'b1;
                rt_data = mem_q[idx].data;
            end
        end
    end

endmodule

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: grant mux between writeback and buffered long-latency
// results, starvation counter and registered pipeline stall.
module grf_wr_arbiter
    import grf_arb_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input logic              clk,
    input logic              Reset_n,
    grf_wr_arbiter_if.slave  bus
);

    localparam int unsigned SC_W = $clog2(STARVE_MAX) + 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(STARVE_MAX - 1);

    logic              fifo_empty;
    logic              fifo_full;
    pend_entry_t       fifo_head;
    logic              rs_hit;
    logic              rt_hit;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    logic              lu_ready;
    logic              push;
    logic              head_grant;
    logic              wb_grant;

    logic              reg_wr;
    logic [ADDR_W-1:0] rw_addr;
    logic [DATA_W-1:0] rw_data;

    logic [SC_W-1:0]   sc_q;
    logic [SC_W-1:0]   sc_d;
    logic              stall_q;
    logic              stall_d;

    // Ready follows the registered count; held low while in reset.
    assign lu_ready = Reset_n & ~fifo_full;
    // Register-0 results complete the handshake but are never buffered.
    assign push     = bus.lu_valid & lu_ready & (bus.lu_addr != REG_ZERO);

    // During a stall the head takes the port and the pipeline re-presents its write.
    assign head_grant = ~fifo_empty & (stall_q | ~bus.wb_we);
    assign wb_grant   = ~head_grant & bus.wb_we;

    grf_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .push      (push),
        .push_addr (bus.lu_addr),
        .push_data (bus.lu_data),
        .pop       (head_grant),
        .kill_en   (wb_grant),
        .kill_addr (bus.wb_addr),
        .qry_rs    (bus.qry_rs),
        .qry_rt    (bus.qry_rt),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (fifo_head),
        .rs_hit    (rs_hit),
        .rs_data   (rs_data),
        .rt_hit    (rt_hit),
        .rt_data   (rt_data)
    );

    // Drive the GRF port from whichever source holds the grant.
    always_comb begin
        reg_wr  = 1'b0;
        rw_addr = '0;
        rw_data = '0;
        if (head_grant) begin
            // A killed head is retired silently.
            reg_wr  = fifo_head.valid & (fifo_head.addr != REG_ZERO);
            rw_addr = fifo_head.addr;
            rw_data = fifo_head.data;
        end else if (wb_grant) begin
            reg_wr  = (bus.wb_addr != REG_ZERO);
            rw_addr = bus.wb_addr;
            rw_data = bus.wb_data;
        end
        if (!Reset_n) begin
            reg_wr = 1'b0;
        end
    end

    // Starvation count and stall request for the next cycle.
    always_comb begin
        sc_d = sc_q;
        if (fifo_empty || head_grant) begin
            sc_d = '0;
        end else if (sc_q != SC_LAST) begin
            sc_d = sc_q + 1'b1;
        end
        stall_d = ((sc_q == SC_LAST) || fifo_full) && !fifo_empty && !head_grant;
    end

    // Starvation counter and stall register.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sc_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            sc_q    <= sc_d;
            stall_q <= stall_d;
        end
    end

    assign bus.lu_ready    = lu_ready;
    assign bus.RegWr       = reg_wr;
    assign bus.RWAddr      = rw_addr;
    assign bus.RWData      = rw_data;
    assign bus.stall_GRF   = stall_q;
    assign bus.fwd_rs_hit  = rs_hit & Reset_n;
    assign bus.fwd_rt_hit  = rt_hit & Reset_n;
    assign bus.fwd_rs_data = rs_data;
    assign bus.fwd_rt_data = rt_data;

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed bench: expected GRF writes go into a scoreboard queue, a negedge monitor
// pops and compares every RegWr; cycle-exact stall/ready/forward checks are inline.
module tb_grf_wr_arbiter;
    import grf_arb_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grf_wr_arbiter_if bus ();

    grf_wr_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    int          wr7_cnt  = 0;
    logic [31:0] last7    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lu_offer(input logic [4:0] addr, input logic [31:0] data);
        bus.lu_valid = 1'b1;
        bus.lu_addr  = addr;
        bus.lu_data  = data;
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every GRF write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.RegWr === 1'b1) begin
            if (bus.RWAddr == 5'd7) begin
                wr7_cnt++;
                last7 = bus.RWData;
            end
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none (t=%0t)",
                         bus.RWAddr, bus.RWData, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bus.RWAddr), 32'(mon_e.addr));
                check("wr_data", bus.RWData, mon_e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.lu_valid = 1'b0;
        bus.lu_addr  = '0;
        bus.lu_data  = '0;
        bus.qry_rs   = '0;
        bus.qry_rt   = '0;

        // Reset state
        @(negedge clk);
        check("rst_stall", 32'(bus.stall_GRF), 32'd0);
        check("rst_ready", 32'(bus.lu_ready), 32'd0);
        check("rst_regwr", 32'(bus.RegWr), 32'd0);
        check("rst_fwd", 32'(bus.fwd_rs_hit), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.lu_ready), 32'd1);

        // 1: LU result written one cycle after acceptance, forwarded for one cycle
        step();
        bus.qry_rs = 5'd5;
        lu_offer(5'd5, 32'h1234);
        expect_wr(5'd5, 32'h1234);
        @(negedge clk);
        check("t1_ready", 32'(bus.lu_ready), 32'd1);
        check("t1_fwd_not_yet", 32'(bus.fwd_rs_hit), 32'd0);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        check("t1_fwd_hit", 32'(bus.fwd_rs_hit), 32'd1);
        check("t1_fwd_data", bus.fwd_rs_data, 32'h1234);
        step();
        @(negedge clk);
        check("t1_fwd_gone", 32'(bus.fwd_rs_hit), 32'd0);

        // 2: starvation under continuous writeback forces a stall after 4 lost cycles
        step();
        bus.wb_we   = 1'b1;
        bus.wb_addr = 5'd0;
        bus.qry_rt  = 5'd3;
        lu_offer(5'd3, 32'h33);
        expect_wr(5'd3, 32'h33);
        step();
        bus.lu_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_stall", 32'(bus.stall_GRF), 32'(k == 4));
            if (k == 0) begin
                check("t2_fwd_rt_hit", 32'(bus.fwd_rt_hit), 32'd1);
                check("t2_fwd_rt_data", bus.fwd_rt_data, 32'h33);
            end
            step();
        end
        bus.wb_we = 1'b0;

        // 3: younger writeback to the same register kills the pending entry
        bus.wb_we  = 1'b1;
        bus.qry_rs = 5'd7;
        lu_offer(5'd7, 32'hAA);
        step();
        bus.lu_valid = 1'b0;
        expect_wr(5'd7, 32'hBB);
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'hBB;
        @(negedge clk);
        check("t3_fwd_before_kill", 32'(bus.fwd_rs_hit), 32'd1);
        check("t3_fwd_data", bus.fwd_rs_data, 32'hAA);
        step();
        bus.wb_we   = 1'b0;
        bus.wb_addr = 5'd0;
        bus.wb_data = '0;
        @(negedge clk);
        check("t3_killed_fwd", 32'(bus.fwd_rs_hit), 32'd0);
        check("t3_killed_nowr", 32'(bus.RegWr), 32'd0);
        step();
        @(negedge clk);
        check("t3_idle_nowr", 32'(bus.RegWr), 32'd0);

        // 4: fill the FIFO behind writeback, stall follows, both drain in order
        step();
        bus.wb_we = 1'b1;
        lu_offer(5'd10, 32'hA0);
        expect_wr(5'd10, 32'hA0);
        step();
        lu_offer(5'd11, 32'hB0);
        expect_wr(5'd11, 32'hB0);
        @(negedge clk);
        check("t4_ready_one", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        check("t4_ready_full", 32'(bus.lu_ready), 32'd0);
        check("t4_stall_early", 32'(bus.stall_GRF), 32'd0);
        step();
        @(negedge clk);
        check("t4_stall", 32'(bus.stall_GRF), 32'd1);
        check("t4_ready_stall", 32'(bus.lu_ready), 32'd0);
        step();
        bus.wb_we = 1'b0;
        @(negedge clk);
        check("t4_stall_drop", 32'(bus.stall_GRF), 32'd0);
        step();
        @(negedge clk);
        check("t4_ready_back", 32'(bus.lu_ready), 32'd1);

        // 5: register-0 result completes the handshake but is never written or forwarded
        step();
        bus.qry_rs = 5'd0;
        bus.qry_rt = 5'd0;
        lu_offer(5'd0, 32'hDEAD);
        @(negedge clk);
        check("t5_ready", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 1'b0;
        @(negedge clk);
        check("t5_nowr", 32'(bus.RegWr), 32'd0);
        check("t5_rs_nohit", 32'(bus.fwd_rs_hit), 32'd0);
        check("t5_rt_nohit", 32'(bus.fwd_rt_hit), 32'd0);
        step();
        @(negedge clk);
        check("t5_nowr2", 32'(bus.RegWr), 32'd0);

        // 6: asynchronous reset mid-stall with two entries pending
        step();
        bus.wb_we  = 1'b1;
        bus.qry_rs = 5'd12;
        lu_offer(5'd12, 32'hC0);
        step();
        lu_offer(5'd13, 32'hD0);
        step();
        bus.lu_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_pre_stall", 32'(bus.stall_GRF), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_stall", 32'(bus.stall_GRF), 32'd0);
        check("t6_rst_ready", 32'(bus.lu_ready), 32'd0);
        check("t6_rst_regwr", 32'(bus.RegWr), 32'd0);
        bus.wb_we = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("t6_post_nowr", 32'(bus.RegWr), 32'd0);
        check("t6_post_ready", 32'(bus.lu_ready), 32'd1);
        check("t6_post_nofwd", 32'(bus.fwd_rs_hit), 32'd0);
        step();
        @(negedge clk);
        check("t6_post_nowr2", 32'(bus.RegWr), 32'd0);
        // A fresh entry drains normally from an empty FIFO.
        step();
        lu_offer(5'd14, 32'hE0);
        expect_wr(5'd14, 32'hE0);
        step();
        bus.lu_valid = 1'b0;
        step();
        step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        check("grf7_final", last7, 32'hBB);
        check("grf7_writes", 32'(wr7_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_wr_arbiter.md
# grf_wr_arbiter

Shares the single GRF write port between the in-order writeback stage and a long-latency result source such as the mult/div unit or a delayed load. Results from the long-latency source are buffered in a small FIFO. Those pending results are forwarded to decode. When the FIFO is starved or full, the block raises a pipeline stall so the buffered result can drain. The block sits directly in front of GRF and drives its `RegWr`/`RWAddr`/`RWData` and `stall_GRF`.

## Interface
- `DEPTH`, 2: FIFO entries for long-latency results (power of two, ≥2).
- `STARVE_MAX`, 4: consecutive cycles a non-empty FIFO head may lose before a stall is forced.

Ports:
- `clk` in 1: single clock, rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `wb_we` in 1: writeback stage requests a write.
- `wb_addr` in 5: writeback destination register.
- `wb_data` in 32: writeback data.
- `lu_valid` in 1: long-latency result offered.
- `lu_addr` in 5: its destination register.
- `lu_data` in 32: its data.
- `lu_ready` out 1: FIFO can accept. Transfer occurs on a rising edge with `lu_valid & lu_ready`.
- `qry_rs`, `qry_rt` in 5 each: decode-stage source registers.
- `fwd_rs_hit`, `fwd_rt_hit` out 1 each: a pending FIFO entry targets the queried register.
- `fwd_rs_data`, `fwd_rt_data` out 32 each: data of the newest matching entry.
- `RegWr` out 1, `RWAddr` out 5, `RWData` out 32: GRF write port.
- `stall_GRF` out 1: registered stall request to the pipeline.

## Operation
- The FIFO holds `{valid, addr, data}` entries with head/tail pointers and a count.
- `lu_ready = (count != DEPTH)`.
- An accepted entry with `lu_addr == 0` is discarded. No entry is allocated, but the handshake still completes.
- Write-port grant:
  - Head wins if the FIFO is non-empty and either `stall_GRF == 1` or `wb_we == 0`.
  - Otherwise writeback wins when `wb_we == 1`.
  - When the head wins during a stall, `wb_we` is ignored for that cycle. The pipeline re-presents the write next cycle.
- Port drive is combinational from the granted source. `RegWr = 0` when nothing is granted or the granted address is 0.
- Killed entries (valid = 0) at the head are popped without asserting `RegWr`.
- WAW kill: when writeback is granted, every valid FIFO entry with `addr == wb_addr` is invalidated on that edge, because the writeback value is younger.
- Starvation counter `sc`:
  - Cleared when the FIFO is empty or the head is granted.
  - Otherwise incremented.
- `stall_GRF` next value = `(sc == STARVE_MAX-1 | count == DEPTH) & FIFO non-empty & !(head granted this cycle)`. It deasserts the cycle after the head drains.
- Forwarding:
  - Compare `qry_rs`/`qry_rt` against valid entries; the newest match wins.
  - Register 0 never hits.
  - A new entry becomes visible the cycle after acceptance.
- Push and pop in the same cycle with the FIFO full is not allowed, since `lu_ready` is computed from registered count.

## Timing
- Reset (`Reset_n` low, asynchronous):
  - count, pointers, `sc` and all entry valids are cleared; `stall_GRF = 0`.
  - `RegWr`, `lu_ready` and the fwd hits are forced to 0 while `Reset_n` is low.
- Latency:
  - Writeback write reaches GRF in the same cycle (combinational).
  - An LU result is written no earlier than one cycle after acceptance.
- Worst-case LU drain is bounded by `STARVE_MAX + 1` cycles per entry.
- A reset asserted mid-stall drops pending entries and deasserts the stall immediately.
- Pointer wrap-around is modulo `DEPTH`.

## Structure
- Shared package `grf_arb_pkg`: `REG_ZERO = 5'd0`, the entry struct/width constants, and defaults for `DEPTH`/`STARVE_MAX`.
- One natural sub-module, `grf_pend_fifo`, holds the storage, pointers, kill-by-address and the newest-match forward lookup.
- The top level holds the grant mux, starvation counter and stall register.

## Test plan
- Reset, then `lu_valid` with addr 5 and data `0x1234` while `wb_we = 0` → next cycle `RegWr = 1`, `RWAddr = 5`, `RWData = 0x1234`, and `fwd` for `$5` hits for exactly one cycle.
- `wb_we = 1` held continuously with one LU entry (addr 3) pending, `STARVE_MAX = 4` → `stall_GRF` rises after 4 lost cycles. The next cycle writes `$3`; the stall drops the following cycle.
- LU entry addr 7 `= 0xAA` pending, then writeback `$7 = 0xBB` granted → the entry is killed, and the final GRF `$7 = 0xBB` with no later write to 7.
- Two LU entries accepted back-to-back while `wb_we = 1` → `lu_ready = 0` and `stall_GRF = 1` the cycle after full. Both drain in order.
- LU with addr 0 → accepted and no `RegWr`. Query `$0` → no hit.
- `Reset_n` pulsed low asynchronously with 2 entries pending and the stall high → immediately `stall_GRF = 0` and `lu_ready = 0`. After release, count = 0 and no spurious write.
